// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
interface fetch_unit_if;
  logic        mem_req_valid;
  logic [15:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [15:0] mem_resp_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;
  logic        inst_ready;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited memory requests, in-order response queue,
// redirect flush with drop counting of stale in-flight responses.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'd10,
  parameter int unsigned DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  fetch_unit_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [15:0]      fetch_pc;
  logic [15:0]      resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [15:0]      pc_mem   [DEPTH];
  logic [15:0]      data_mem [DEPTH];
  logic             post_rst;

  logic credit_ok;
  logic req_valid;
  logic inst_valid;
  logic redirect;
  logic req_fire;
  logic resp_fire;
  logic push;
  logic pop;

  // Credits cover both in-flight requests and queued instructions, so a push never finds the queue full.
  always_comb begin
    credit_ok  = (SUM_W'(outstanding) + SUM_W'(fifo_count)) < SUM_W'(DEPTH);
    req_valid  = clk_en & ~rst & ~post_rst & ~bus.redirect_valid & credit_ok;
    inst_valid = ~rst & ~post_rst & (fifo_count != '0) & ~bus.redirect_valid;
    redirect   = bus.redirect_valid & clk_en;
    req_fire   = req_valid & bus.mem_req_ready;
    resp_fire  = clk_en & bus.mem_resp_valid;
    push       = resp_fire & (drop == '0) & ~redirect;
    pop        = inst_valid & bus.inst_ready & clk_en;
  end

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc;
  assign bus.inst_valid    = inst_valid;
  assign bus.inst_data     = data_mem[rd_ptr];
  assign bus.inst_pc       = pc_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      post_rst    <= 1'b1;
    end else begin
      post_rst <= 1'b0;
      if (clk_en) begin
        if (redirect) begin
          // Everything still in flight after this cycle belongs to the old stream.
          fetch_pc    <= bus.redirect_pc;
          resp_pc     <= bus.redirect_pc;
          outstanding <= outstanding - CNT_W'(resp_fire);
          drop        <= outstanding - CNT_W'(resp_fire);
          fifo_count  <= '0;
          wr_ptr      <= '0;
          rd_ptr      <= '0;
        end else begin
          if (req_fire) fetch_pc <= fetch_pc + 16'd1;
          if (resp_fire && drop != '0) drop <= drop - CNT_W'(1);
          if (push) begin
            resp_pc <= resp_pc + 16'd1;
            wr_ptr  <= wr_ptr + PTR_W'(1);
          end
          if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
          outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(resp_fire);
          fifo_count  <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      data_mem[wr_ptr] <= bus.mem_resp_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> (fifo_count != CNT_W'(DEPTH)));

  a_resp_has_request: assert property (@(posedge clk) disable iff (rst)
    resp_fire |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with variable latency and an
// epoch-based scoreboard of the expected instruction and request streams.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(16'd10), .DEPTH(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_pc     = 16'd10;
  logic [15:0] exp_req_pc = 16'd10;
  int          queued     = 0;
  int          epoch      = 0;
  bit          prev_rst   = 1'b0;
  int          lat_min    = 0;
  int          lat_max    = 0;

  logic [15:0] pend_addr  [$];
  int          pend_wait  [$];
  int          pend_epoch [$];
  logic [15:0] got_pc     [$];
  logic [15:0] req_log    [$];

  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a * 16'd37) ^ 16'hC3A5;
  endfunction

  // One clock: sample and score before the edge, then advance the model and memory.
  task automatic cycle();
    logic        s_req, s_resp, s_inst, s_redir, s_rst, s_en;
    logic [15:0] s_addr, s_rpc;
    logic        exp_req, exp_iv;
    @(negedge clk);
    s_en    = clk_en;
    s_rst   = rst;
    s_redir = bus.redirect_valid;
    s_rpc   = bus.redirect_pc;
    s_req   = bus.mem_req_valid & bus.mem_req_ready;
    s_addr  = bus.mem_req_addr;
    s_resp  = bus.mem_resp_valid & clk_en & ~rst;
    s_inst  = bus.inst_valid & bus.inst_ready & clk_en;
    exp_req = clk_en && !rst && !prev_rst && !s_redir && ((pend_addr.size() + queued) < 2);
    exp_iv  = !rst && !s_redir && (queued > 0);
    total++;
    if (bus.mem_req_valid !== exp_req) begin
      bad++;
      $display("FAIL req_valid t=%0t got=%b exp=%b", $time, bus.mem_req_valid, exp_req);
    end
    total++;
    if (bus.inst_valid !== exp_iv) begin
      bad++;
      $display("FAIL inst_valid t=%0t got=%b exp=%b", $time, bus.inst_valid, exp_iv);
    end
    if (s_req) begin
      total++;
      if (s_addr !== exp_req_pc) begin
        bad++;
        $display("FAIL req_addr t=%0t got=%h exp=%h", $time, s_addr, exp_req_pc);
      end
      req_log.push_back(s_addr);
    end
    if (s_inst) begin
      total++;
      if (bus.inst_pc !== exp_pc || bus.inst_data !== memf(exp_pc)) begin
        bad++;
        $display("FAIL inst t=%0t got pc=%h data=%h exp pc=%h data=%h",
                 $time, bus.inst_pc, bus.inst_data, exp_pc, memf(exp_pc));
      end
      got_pc.push_back(bus.inst_pc);
    end
    @(posedge clk);
    #1;
    prev_rst = s_rst;
    if (s_rst) begin
      pend_addr.delete(); pend_wait.delete(); pend_epoch.delete();
      queued = 0; epoch++;
      exp_pc = 16'd10; exp_req_pc = 16'd10;
    end else if (s_en) begin
      if (s_inst) begin queued--; exp_pc = exp_pc + 16'd1; end
      if (s_resp && pend_addr.size() > 0) begin
        if (pend_epoch[0] == epoch) queued++;
        void'(pend_addr.pop_front()); void'(pend_wait.pop_front()); void'(pend_epoch.pop_front());
      end
      if (s_req) exp_req_pc = exp_req_pc + 16'd1;
      if (s_redir) begin
        queued = 0; epoch++;
        exp_pc = s_rpc; exp_req_pc = s_rpc;
      end
      if (pend_wait.size() > 0 && pend_wait[0] > 0) pend_wait[0] = pend_wait[0] - 1;
      if (s_req) begin
        pend_addr.push_back(s_addr);
        pend_wait.push_back(int'($urandom_range(lat_max, lat_min)));
        pend_epoch.push_back(epoch);
      end
    end
    bus.mem_resp_valid = (pend_addr.size() > 0) && (pend_wait[0] == 0);
    bus.mem_resp_data  = (pend_addr.size() > 0) ? memf(pend_addr[0]) : 16'h0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_idle();
    clk_en = 1'b1; rst = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 16'h0;
    bus.inst_ready = 1'b1; bus.mem_req_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1; clk_en = 1'b0;
    run(2);
    rst = 1'b0; clk_en = 1'b1;
    #1;
    total++;
    if (bus.mem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_after got req=%b iv=%b exp 0 0", bus.mem_req_valid, bus.inst_valid);
    end
    cycle();
    #1;
    total++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 16'd10) begin
      bad++;
      $display("FAIL reset_first_req got v=%b a=%h exp 1 000a", bus.mem_req_valid, bus.mem_req_addr);
    end
  endtask

  task automatic test_stream();
    set_idle(); lat_min = 0; lat_max = 0;
    do_reset();
    got_pc.delete();
    run(24);
    total++;
    if (got_pc.size() < 8) begin
      bad++;
      $display("FAIL stream_count got=%0d exp>=8", got_pc.size());
    end
    for (int i = 0; i < 8 && i < got_pc.size(); i++) begin
      total++;
      if (got_pc[i] !== 16'(10 + i)) begin
        bad++;
        $display("FAIL stream_pc[%0d] got=%h exp=%h", i, got_pc[i], 16'(10 + i));
      end
    end
  endtask

  task automatic test_backpressure();
    set_idle(); lat_min = 0; lat_max = 0;
    do_reset();
    bus.inst_ready = 1'b0;
    req_log.delete();
    run(8);
    #1;
    total++;
    if (req_log.size() != 2 || req_log[0] !== 16'd10 || req_log[1] !== 16'd11) begin
      bad++;
      $display("FAIL bp_reqs got count=%0d exp 2 (10, 11)", req_log.size());
    end
    total++;
    if (bus.mem_req_valid !== 1'b0 || bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'd10) begin
      bad++;
      $display("FAIL bp_hold got req=%b iv=%b pc=%h exp 0 1 000a",
               bus.mem_req_valid, bus.inst_valid, bus.inst_pc);
    end
    bus.inst_ready = 1'b1;
    run(6);
    total++;
    if (req_log.size() < 3 || req_log[2] !== 16'd12) begin
      bad++;
      $display("FAIL bp_resume got count=%0d exp third req at 000c", req_log.size());
    end
  endtask

  task automatic test_redirect();
    set_idle(); lat_min = 4; lat_max = 4;
    do_reset();
    run(4);
    #1;
    total++;
    if (bus.mem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_setup got req=%b iv=%b exp 0 0", bus.mem_req_valid, bus.inst_valid);
    end
    got_pc.delete();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0040;
    cycle();
    bus.redirect_valid = 1'b0;
    lat_min = 0; lat_max = 0;
    run(30);
    total++;
    if (got_pc.size() < 3) begin
      bad++;
      $display("FAIL redir_count got=%0d exp>=3", got_pc.size());
    end
    for (int i = 0; i < got_pc.size(); i++) begin
      total++;
      if (got_pc[i] !== 16'(16'h0040 + i)) begin
        bad++;
        $display("FAIL redir_pc[%0d] got=%h exp=%h", i, got_pc[i], 16'(16'h0040 + i));
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] want [3];
    want[0] = 16'hFFFF; want[1] = 16'h0000; want[2] = 16'h0001;
    set_idle(); lat_min = 0; lat_max = 1;
    do_reset();
    run(4);
    got_pc.delete();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'hFFFF;
    cycle();
    bus.redirect_valid = 1'b0;
    run(20);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= got_pc.size() || got_pc[i] !== want[i]) begin
        bad++;
        $display("FAIL wrap_pc[%0d] got=%h exp=%h", i,
                 (i < got_pc.size()) ? got_pc[i] : 16'hxxxx, want[i]);
      end
    end
  endtask

  task automatic test_clk_en();
    logic        iv0;
    logic [15:0] pc0;
    set_idle(); lat_min = 0; lat_max = 0;
    do_reset();
    run(10);
    got_pc.delete();
    #1;
    iv0 = bus.inst_valid; pc0 = bus.inst_pc;
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (bus.mem_req_valid !== 1'b0 || bus.inst_valid !== iv0 || (iv0 && bus.inst_pc !== pc0)) begin
        bad++;
        $display("FAIL stall[%0d] got req=%b iv=%b pc=%h exp 0 %b %h",
                 i, bus.mem_req_valid, bus.inst_valid, bus.inst_pc, iv0, pc0);
      end
      cycle();
    end
    clk_en = 1'b1;
    run(12);
    total++;
    if (got_pc.size() < 4) begin
      bad++;
      $display("FAIL stall_resume_count got=%0d exp>=4", got_pc.size());
    end
    for (int i = 1; i < got_pc.size(); i++) begin
      total++;
      if (got_pc[i] !== got_pc[0] + 16'(i)) begin
        bad++;
        $display("FAIL stall_seq[%0d] got=%h exp=%h", i, got_pc[i], got_pc[0] + 16'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    set_idle(); lat_min = 0; lat_max = 2;
    do_reset();
    run(6);
    bus.inst_ready = 1'b0;
    run(10);
    #1;
    total++;
    if (bus.inst_valid !== 1'b1) begin
      bad++;
      $display("FAIL rmid_full got iv=%b exp 1", bus.inst_valid);
    end
    do_reset();
    #1;
    total++;
    if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_after got iv=%b req=%b exp 0 0", bus.inst_valid, bus.mem_req_valid);
    end
    req_log.delete(); got_pc.delete();
    bus.inst_ready = 1'b1;
    run(10);
    total++;
    if (req_log.size() < 1 || req_log[0] !== 16'd10 || got_pc.size() < 1 || got_pc[0] !== 16'd10) begin
      bad++;
      $display("FAIL rmid_restart got reqs=%0d insts=%0d exp first req and inst at 000a",
               req_log.size(), got_pc.size());
    end
  endtask

  task automatic test_random();
    set_idle(); lat_min = 0; lat_max = 3;
    do_reset();
    got_pc.delete();
    for (int i = 0; i < 3000; i++) begin
      clk_en             = ($urandom % 10) != 0;
      bus.redirect_valid = ($urandom % 25) == 0;
      bus.redirect_pc    = 16'($urandom);
      bus.inst_ready     = ($urandom % 3) != 0;
      bus.mem_req_ready  = ($urandom % 4) != 0;
      rst                = ($urandom % 200) == 0;
      cycle();
    end
    set_idle();
    run(4);
    total++;
    if (got_pc.size() < 200) begin
      bad++;
      $display("FAIL random_progress got=%0d exp>=200", got_pc.size());
    end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0;
    bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 16'h0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 16'h0; bus.inst_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_clk_en();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'd10, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the instruction queue depth (power of two, >=2).
REQ-003 SHALL have clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have clk_en  input  1  global stall; state advances only when high.
REQ-006 SHALL have mem_req_valid  output  1  fetch request valid.
REQ-007 SHALL have mem_req_addr  output  16  word address of the fetch request.
REQ-008 SHALL have mem_req_ready  input  1  memory accepts the request.
REQ-009 SHALL have mem_resp_valid  input  1  read data returned, in request order, always accepted.
REQ-010 SHALL have mem_resp_data  input  16  returned instruction word.
REQ-011 SHALL have redirect_valid  input  1  branch/jump redirect from downstream.
REQ-012 SHALL have redirect_pc  input  16  redirect target address.
REQ-013 SHALL have inst_valid  output  1  instruction available to decode.
REQ-014 SHALL have inst_data  output  16  instruction word.
REQ-015 SHALL have inst_pc  output  16  address of inst_data.
REQ-016 SHALL have inst_ready  input  1  decode consumes the instruction.

Function
REQ-017 SHALL hold fetch_pc (next request address), resp_pc (address of the next kept response), outstanding count, drop count and a DEPTH-entry FIFO of {pc, data}.
REQ-018 SHALL drive mem_req_valid = clk_en & ~rst & ~redirect_valid & (outstanding + fifo_count < DEPTH); mem_req_addr = fetch_pc.
REQ-019 SHALL accept a request when mem_req_valid & mem_req_ready: fetch_pc increments by 1 modulo 2^16 (0xFFFF -> 0x0000), outstanding increments.
REQ-020 SHALL sample mem_resp_valid only when clk_en is high; the memory shares clk_en and rst.
REQ-021 SHALL, on a response with drop count > 0, discard the data and decrement both drop and outstanding.
REQ-022 SHALL, on a response with drop count = 0, push {resp_pc, mem_resp_data} into the FIFO, increment resp_pc modulo 2^16 and decrement outstanding.
REQ-023 SHALL never overflow the FIFO; the credit rule in REQ-018 guarantees space, and a push into a full FIFO is a design error flagged by assertion.
REQ-024 SHALL present the FIFO head on inst_data/inst_pc with inst_valid = (fifo_count > 0) & ~redirect_valid; a response reaches inst_valid one cycle after mem_resp_valid, with no bypass.
REQ-025 SHALL pop the FIFO when inst_valid & inst_ready & clk_en; push and pop may occur in the same cycle.
REQ-026 SHALL, on redirect_valid & clk_en: flush the FIFO, set fetch_pc and resp_pc to redirect_pc, set drop = outstanding minus any response dropped or kept this cycle, and issue no request that cycle.
REQ-027 SHALL give redirect priority over push, pop and request in the same cycle.
REQ-028 SHALL, when clk_en is low, hold all state, force mem_req_valid low, and keep inst_valid at its registered value without popping.
REQ-029 SHALL compute counter widths as $clog2(DEPTH)+1, with no wrap of outstanding or drop.

Reset
REQ-030 SHALL, while rst is high on a clock edge: fetch_pc = resp_pc = RESET_PC, outstanding = drop = fifo_count = 0, FIFO pointers = 0.
REQ-031 SHALL drive mem_req_valid = 0 and inst_valid = 0 during and in the cycle after reset, regardless of clk_en; inst_data and inst_pc are don't-care while inst_valid = 0.
REQ-032 SHALL treat reset mid-operation as discarding all outstanding requests and queued instructions, with no stale data emitted afterwards.

Verification
REQ-033 Reset release, mem_req_ready = 1, 1-cycle memory latency, inst_ready = 1 -> requests at 10, 11, 12...; inst_pc follows 10, 11, 12... with inst_data = mem[inst_pc].
REQ-034 inst_ready = 0 from reset -> exactly 2 requests (10, 11), then mem_req_valid stays 0 and inst_valid holds pc 10; inst_ready = 1 -> requests resume at 12 with no gap or duplicate.
REQ-035 Redirect to 0x0040 with 2 outstanding requests -> both responses dropped, FIFO empty, next inst_pc = 0x0040, and no pc from the old stream ever appears.
REQ-036 Redirect to 0xFFFF -> inst_pc sequence 0xFFFF, 0x0000, 0x0001.
REQ-037 clk_en low for 3 cycles mid-stream -> mem_req_valid = 0 and no state change; the sequence continues without gap or duplicate.
REQ-038 rst for 1 cycle with a full FIFO and outstanding requests -> inst_valid = 0 the next cycle, and the first request after reset is at address 10.
